// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: message-schedule FSM states, sigma rotate/shift
// amounts for the 32-bit and 64-bit variants, and the standard round counts.
package sha2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } sched_state_t;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    // SHA-256 small sigmas
    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    // SHA-512 small sigmas
    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

endpackage

// File: rtl/wsched_sigma.sv
// Combinational small-sigma function of the SHA-2 message schedule.
// UPPER=0 selects sigma0, UPPER=1 selects sigma1; WORD_W picks SHA-256/512 constants.
module wsched_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter bit UPPER  = 1'b0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int R1 = (WORD_W == 64) ? (UPPER ? S512_S1_R1 : S512_S0_R1)
                                       : (UPPER ? S256_S1_R1 : S256_S0_R1);
    localparam int R2 = (WORD_W == 64) ? (UPPER ? S512_S1_R2 : S512_S0_R2)
                                       : (UPPER ? S256_S1_R2 : S256_S0_R2);
    localparam int SH = (WORD_W == 64) ? (UPPER ? S512_S1_SH : S512_S0_SH)
                                       : (UPPER ? S256_S1_SH : S256_S0_SH);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    // Two rotations and one logical shift, XORed together.
    always_comb begin
        y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);
    end

endmodule

// File: rtl/msg_sched_gen.sv
// SHA-2 message schedule generator: accepts 16 message words, streams W_0..W_(ROUNDS-1).
// Optional macro WSCHED_ABORT_EN adds an 'abort' input that clears all state like reset.
module msg_sched_gen
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = ROUNDS_256
) (
    input  logic              clk,
    input  logic              reset,
`ifdef WSCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_idx,
    output logic              w_last,
    output logic              busy
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    sched_state_t      state;
    logic [6:0]        t;
    logic [WORD_W-1:0] win [16];

    logic              adv;
    logic              flush;
    logic              accept_m;
    logic              load;
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] w_exp;
    logic [WORD_W-1:0] w_in;

    wsched_sigma #(.WORD_W(WORD_W), .UPPER(1'b0)) u_sigma0 (.x(win[14]), .y(s0));
    wsched_sigma #(.WORD_W(WORD_W), .UPPER(1'b1)) u_sigma1 (.x(win[1]),  .y(s1));

`ifdef WSCHED_ABORT_EN
    assign flush = reset || abort;
`else
    assign flush = reset;
`endif

    assign adv     = !w_valid || w_ready;
    assign m_ready = ((state == IDLE) || (state == LOAD)) && adv && !flush;
    assign busy    = (state != IDLE);

    // Next schedule word: from the message during IDLE/LOAD, from the recurrence in EXPAND.
    always_comb begin
        w_exp    = s1 + win[6] + s0 + win[15];
        accept_m = m_ready && m_valid;
        if (state == EXPAND) begin
            w_in = w_exp;
            load = adv;
        end else begin
            w_in = m_data;
            load = accept_m;
        end
    end

    // FSM, window shift register and the single output register stage.
    always_ff @(posedge clk) begin
        if (flush) begin
            state   <= IDLE;
            t       <= 7'd0;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_idx   <= 7'd0;
            w_last  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win[k] <= '0;
            end
        end else if (load) begin
            for (int k = 15; k > 0; k--) begin
                win[k] <= win[k-1];
            end
            win[0]  <= w_in;
            w_valid <= 1'b1;
            w_data  <= w_in;
            w_idx   <= t;
            w_last  <= (t == LAST_T);
            case (state)
                IDLE: begin
                    state <= LOAD;
                    t     <= 7'd1;
                end
                LOAD: begin
                    t <= t + 7'd1;
                    if (t == 7'd15) begin
                        state <= EXPAND;
                    end else begin
                        state <= LOAD;
                    end
                end
                EXPAND: begin
                    if (t == LAST_T) begin
                        state <= IDLE;
                        t     <= 7'd0;
                    end else begin
                        state <= EXPAND;
                        t     <= t + 7'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    t     <= 7'd0;
                end
            endcase
        end else if (adv) begin
            w_valid <= 1'b0;
        end else begin
            w_valid <= w_valid;
        end
    end

endmodule

// File: tb/tb_msg_sched_gen.sv
// Scoreboard bench for msg_sched_gen: a 32-bit/64-round and a 64-bit/80-round instance.
module tb_msg_sched_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        abort = 1'b0;

    logic        m_valid_a, m_ready_a, w_valid_a, w_ready_a, w_last_a, busy_a;
    logic [31:0] m_data_a, w_data_a;
    logic [6:0]  w_idx_a;

    logic        m_valid_b, m_ready_b, w_valid_b, w_last_b, busy_b;
    logic [63:0] m_data_b, w_data_b;
    logic [6:0]  w_idx_b;

    msg_sched_gen #(.WORD_W(32), .ROUNDS(64)) dut_a (
        .clk(clk), .reset(reset),
`ifdef WSCHED_ABORT_EN
        .abort(abort),
`endif
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
        .w_idx(w_idx_a), .w_last(w_last_a), .busy(busy_a)
    );

    msg_sched_gen #(.WORD_W(64), .ROUNDS(80)) dut_b (
        .clk(clk), .reset(reset),
`ifdef WSCHED_ABORT_EN
        .abort(abort),
`endif
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .w_valid(w_valid_b), .w_ready(1'b1), .w_data(w_data_b),
        .w_idx(w_idx_b), .w_last(w_last_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [6:0]  idx;
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [63:0] abc32 [16];
    logic [63:0] alt32 [16];
    logic [63:0] abc64 [16];
    logic [63:0] wm [128];

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> r) | (x << (w - r))) & m;
    endfunction

    function automatic logic [63:0] ssig(input logic [63:0] x, input bit up, input int w);
        if (w == 64)
            return up ? (rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6))
                      : (rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7));
        else
            return up ? (rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10))
                      : (rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3));
    endfunction

    // Model the full schedule of a block and queue every expected output word.
    task automatic push_block(input bit wide, input logic [63:0] blk [16], input bit hand);
        int w;
        int r;
        logic [63:0] mask;
        exp_t e;
        w    = wide ? 64 : 32;
        r    = wide ? 80 : 64;
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int k = 0; k < 16; k++) wm[k] = blk[k] & mask;
        for (int k = 16; k < r; k++)
            wm[k] = (ssig(wm[k-2], 1'b1, w) + wm[k-7] + ssig(wm[k-15], 1'b0, w) + wm[k-16]) & mask;
        if (hand && !wide) begin
            wm[16] = 64'h0000_0000_6162_6380;
            wm[17] = 64'h0000_0000_000F_0000;
            wm[18] = 64'h0000_0000_7DA8_6405;
            wm[19] = 64'h0000_0000_6000_03C6;
        end
        if (hand && wide) wm[16] = 64'h6162_6380_0000_0000;
        for (int k = 0; k < r; k++) begin
            e.idx  = 7'(k);
            e.data = wm[k];
            e.last = (k == r - 1);
            if (wide) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    task automatic send(input bit wide, input logic [63:0] blk [16]);
        bit got;
        for (int k = 0; k < 16; k++) begin
            if (wide) begin m_valid_b = 1'b1; m_data_b = blk[k]; end
            else      begin m_valid_a = 1'b1; m_data_a = blk[k][31:0]; end
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                got = wide ? m_ready_b : m_ready_a;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %0d not accepted, got m_ready 0 expected 1", k);
            end
        end
        m_valid_a = 1'b0;
        m_valid_b = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d words pending expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic wait_idx(input int k);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            hit = w_valid_a && (w_idx_a == 7'(k));
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_idx: index %0d never seen, got w_idx %0d", k, w_idx_a);
        end
    endtask

    // w_ready source: fixed level or ~50% random stalls.
    bit rnd_ready = 1'b0;
    bit ready_fixed = 1'b1;
    initial begin
        w_ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready_a = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit   span_arm = 1'b0;
    int   span_n, span_first, span_last;
    bit   stall_a = 1'b0;
    logic [31:0] hold_d;
    logic [6:0]  hold_i;
    logic        hold_l;
    exp_t e_a, e_b;

    // Monitor A: scoreboard pop on each transfer plus stability check across stalls.
    always @(negedge clk) begin
        if (reset || abort) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("stall_valid", w_valid_a, 1'b1);
                chk("stall_data", w_data_a, hold_d);
                chk("stall_idx", w_idx_a, hold_i);
                chk("stall_last", w_last_a, hold_l);
            end
            if (w_valid_a && w_ready_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word_a: got idx %0d expected no word", w_idx_a);
                end else begin
                    e_a = q_a.pop_front();
                    chk("w_idx_a", w_idx_a, e_a.idx);
                    chk("w_data_a", w_data_a, e_a.data);
                    chk("w_last_a", w_last_a, e_a.last);
                end
                if (span_arm) begin
                    if (span_n == 0) span_first = cyc;
                    span_last = cyc;
                    span_n++;
                end
            end
            stall_a = w_valid_a && !w_ready_a;
            hold_d  = w_data_a;
            hold_i  = w_idx_a;
            hold_l  = w_last_a;
        end
    end

    // Monitor B: 64-bit instance, always ready.
    always @(negedge clk) begin
        if (!reset && !abort && w_valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word_b: got idx %0d expected no word", w_idx_b);
            end else begin
                e_b = q_b.pop_front();
                chk("w_idx_b", w_idx_b, e_b.idx);
                chk("w_data_b", w_data_b, e_b.data);
                chk("w_last_b", w_last_b, e_b.last);
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            abc32[k] = 64'd0;
            abc64[k] = 64'd0;
            alt32[k] = (64'h9E37_79B9 * 64'(k + 1)) & 64'h0000_0000_FFFF_FFFF;
        end
        abc32[0]  = 64'h0000_0000_6162_6380;
        abc32[15] = 64'h0000_0000_0000_0018;
        abc64[0]  = 64'h6162_6380_0000_0000;
        abc64[15] = 64'h0000_0000_0000_0018;

        reset = 1'b1;
        m_valid_a = 1'b0; m_data_a = 32'd0;
        m_valid_b = 1'b0; m_data_b = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_valid", w_valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_w_data", w_data_a, 32'd0);
        chk("rst_w_idx", w_idx_a, 7'd0);
        chk("rst_w_last", w_last_a, 1'b0);
        chk("rst_m_ready", m_ready_a, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_m_ready", m_ready_a, 1'b1);

        // SHA-256 "abc", consumer always ready
        push_block(1'b0, abc32, 1'b1);
        send(1'b0, abc32);
        chk("busy_expand", busy_a, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("idle_w_valid", w_valid_a, 1'b0);
        chk("idle_busy", busy_a, 1'b0);

        // SHA-512 "abc", 80 rounds
        push_block(1'b1, abc64, 1'b1);
        send(1'b1, abc64);
        drain();
        chk("idle_busy_b", busy_b, 1'b0);

        // Random consumer stalls
        rnd_ready = 1'b1;
        push_block(1'b0, abc32, 1'b1);
        send(1'b0, abc32);
        drain();
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of expansion
        push_block(1'b0, abc32, 1'b0);
        send(1'b0, abc32);
        wait_idx(30);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q_a.delete();
        @(posedge clk);
        #1;
        chk("midrst_w_valid", w_valid_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_m_ready", m_ready_a, 1'b0);
        reset = 1'b0;
        push_block(1'b0, abc32, 1'b1);
        send(1'b0, abc32);
        drain();

        // Two blocks back to back without a bubble
        span_n = 0;
        span_arm = 1'b1;
        push_block(1'b0, abc32, 1'b0);
        push_block(1'b0, alt32, 1'b0);
        send(1'b0, abc32);
        send(1'b0, alt32);
        drain();
        span_arm = 1'b0;
        chk("b2b_count", 64'(span_n), 64'd128);
        chk("b2b_span", 64'(span_last - span_first), 64'd127);

`ifdef WSCHED_ABORT_EN
        // Abort in the middle of expansion
        push_block(1'b0, abc32, 1'b0);
        send(1'b0, abc32);
        wait_idx(20);
        @(posedge clk);
        #1;
        abort = 1'b1;
        q_a.delete();
        @(posedge clk);
        #1;
        chk("abort_w_valid", w_valid_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        abort = 1'b0;
        push_block(1'b0, alt32, 1'b0);
        send(1'b0, alt32);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_sched_gen.md
MSG_SCHED_GEN -- requirements
Module: msg_sched_gen

Interface
REQ-001 SHALL have parameter WORD_W, default 32, schedule word width; legal values are 32 (SHA-256) and 64 (SHA-512).
REQ-002 SHALL have parameter ROUNDS, default 64, number of W words per block; legal range is 17 to 127 (80 for SHA-512).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port m_valid, input, 1, message word offered.
REQ-006 SHALL have port m_ready, output, 1, message word accepted this cycle when m_valid is also high.
REQ-007 SHALL have port m_data, input, WORD_W, message word M_t, most significant word first.
REQ-008 SHALL have port w_valid, output, 1, w_data and w_idx are valid.
REQ-009 SHALL have port w_ready, input, 1, consumer takes the word this cycle when w_valid is also high.
REQ-010 SHALL have port w_data, output, WORD_W, schedule word W_t.
REQ-011 SHALL have port w_idx, output, 7, round index t of w_data.
REQ-012 SHALL have port w_last, output, 1, high with w_valid when t equals ROUNDS-1.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and EXPAND with a round counter t (7 bits) and a 16-entry window; win[k] holds W_(t-1-k).
REQ-015 SHALL go from IDLE to LOAD with t=1 on the first accepted m word, that word being W_0.
REQ-016 SHALL, in LOAD, take W_t = m_data on each accepted word; after W_15 it SHALL enter EXPAND.
REQ-017 SHALL, in EXPAND, take W_t = sigma1(win[1]) + win[6] + sigma0(win[14]) + win[15], mod 2^WORD_W, with no carry out.
REQ-018 SHALL use, for WORD_W=32: sigma0 = ROTR7^ROTR18^SHR3 and sigma1 = ROTR17^ROTR19^SHR10.
REQ-019 SHALL use, for WORD_W=64: sigma0 = ROTR1^ROTR8^SHR7 and sigma1 = ROTR19^ROTR61^SHR6.
REQ-020 SHALL hold the output in a single register stage: a new W_t loads when !w_valid || w_ready ("adv"), so W_t appears on w_data one cycle after it is accepted or generated.
REQ-021 SHALL drive m_ready = (state is IDLE or LOAD) && adv && !reset; m_ready SHALL be 0 in EXPAND.
REQ-022 SHALL generate an EXPAND word only when adv is high; while adv is low, t and win are held.
REQ-023 SHALL keep w_data, w_idx and w_last stable while w_valid && !w_ready.
REQ-024 SHALL return to IDLE, with t=0, when W_(ROUNDS-1) is generated.
REQ-025 SHALL allow an m word in IDLE to be accepted in the same cycle that the last word drains, giving back-to-back blocks without a bubble.
REQ-026 SHALL, in IDLE with no input, set w_valid=0 once the pending word is taken.

Reset
REQ-027 SHALL, at a reset edge, set state=IDLE, t=0, all win=0, w_valid=0, w_data=0, w_idx=0, w_last=0 and busy=0.
REQ-028 SHALL, on reset mid-block, drop the partial block with no further output; m_ready SHALL be 0 while reset is high.

Configuration
REQ-029 SHALL, with WSCHED_ABORT_EN defined, add input port abort (1 bit); abort high at an edge acts like reset on all state, with lower priority than reset and higher priority than the handshakes.
REQ-030 SHALL, without WSCHED_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-031 SHALL take from the shared package sha2_pkg: the FSM state enum, the sigma rotate/shift constants per WORD_W, and the ROUNDS constants 64 and 80.
REQ-032 SHALL put sigma0 and sigma1 in a sub-module wsched_sigma (parameter WORD_W, combinational), with two instances.

Verification
REQ-033 SHALL check SHA-256 "abc" (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), with w_ready held high -> W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405, W_19=0x600003C6, W_63 matches the model, w_last only at t=63.
REQ-034 SHALL check WORD_W=64, ROUNDS=80, "abc" (W_0=0x6162638000000000, W_15=0x18) -> W_16=0x6162638000000000, 80 words, w_last at t=79.
REQ-035 SHALL check random w_ready stalls (about 50%) on the "abc" block -> the same 64 words in order, with no word dropped or repeated and outputs stable during stall.
REQ-036 SHALL check reset asserted at t=30 -> next cycle w_valid=0 and busy=0; a new block then gives the correct W_16.
REQ-037 SHALL check two blocks sent back to back -> 128 words with no gap when w_ready is high, and w_idx wrapping 63 -> 0.
REQ-038 SHALL check, with WSCHED_ABORT_EN, abort at t=20 -> IDLE, w_valid=0, and a following block is correct.
